// File: rtl/urv_tcm_pkg.sv
// urv_tcm_pkg: shared types and size helpers for the uRV tightly-coupled memory.
package urv_tcm_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } tcm_state_e;

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   function automatic int unsigned bytes_per_word(input int unsigned data_width);
      return data_width / 8;
   endfunction

   function automatic int unsigned word_count(input int unsigned size_bytes,
                                              input int unsigned data_width);
      return size_bytes / (data_width / 8);
   endfunction

endpackage

// File: rtl/urv_tcm_clear_fsm.sv
// urv_tcm_clear_fsm: zero-initialisation sequencer. Walks every word once after
// reset release, then reports ready. With clearing disabled it is ready at once.
module urv_tcm_clear_fsm
   import urv_tcm_pkg::*;
#(
   parameter int unsigned g_words          = 256,
   parameter int unsigned g_clear_on_reset = 1,
   localparam int unsigned c_aw            = clog2(g_words)
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   output logic            ready_o,
   output logic            clr_we_o,
   output logic [c_aw-1:0] clr_addr_o
);

   localparam tcm_state_e      c_rst_state = (g_clear_on_reset != 0) ? ST_CLEAR : ST_READY;
   localparam logic [c_aw-1:0] c_last      = c_aw'(g_words - 1);

   tcm_state_e      state_q, state_d;
   logic [c_aw-1:0] cnt_q, cnt_d;

   // State and clear counter registers; reset restarts the sweep from word 0.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= c_rst_state;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: one zero write per cycle, the final write hands over to READY.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_we_o = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we_o = 1'b1;
            if (cnt_q == c_last) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
      endcase
   end

   assign clr_addr_o = cnt_q;
   assign ready_o    = (state_q == ST_READY);

endmodule

// File: rtl/urv_tcm.sv
// urv_tcm: dual-port tightly-coupled memory for uRV (port A fetch, port B data).
// Optional macro URV_TCM_PARITY_EN adds per-byte even parity and perr_a_o/perr_b_o.
module urv_tcm
   import urv_tcm_pkg::*;
#(
   parameter int unsigned g_data_width     = 32,
   parameter int unsigned g_size           = 65536,
   parameter int unsigned g_out_reg        = 0,
   parameter int unsigned g_clear_on_reset = 1,
   parameter string       g_init_file      = ""
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   output logic                      ready_o,
   input  logic                      ena_i,
   input  logic                      wea_i,
   input  logic [31:0]               aa_i,
   input  logic [g_data_width/8-1:0] bwea_i,
   input  logic [g_data_width-1:0]   da_i,
   output logic [g_data_width-1:0]   qa_o,
   output logic                      qa_valid_o,
   input  logic                      enb_i,
   input  logic                      web_i,
   input  logic [31:0]               ab_i,
   input  logic [g_data_width/8-1:0] bweb_i,
   input  logic [g_data_width-1:0]   db_i,
   output logic [g_data_width-1:0]   qb_o,
   output logic                      qb_valid_o,
   output logic                      collision_o
`ifdef URV_TCM_PARITY_EN
   ,
   output logic                      perr_a_o,
   output logic                      perr_b_o
`endif
);

   localparam int unsigned c_nb    = bytes_per_word(g_data_width);
   localparam int unsigned c_words = word_count(g_size, g_data_width);
   localparam int unsigned c_aw    = clog2(c_words);
   localparam int unsigned c_ob    = clog2(c_nb);
   localparam int unsigned c_top   = clog2(g_size);

   typedef logic [g_data_width-1:0] word_t;

   word_t           mem_q [c_words];
   logic            clr_we;
   logic [c_aw-1:0] clr_addr;
   logic [c_aw-1:0] idx_a, idx_b;
   logic            acc_a, acc_b;
   logic [c_nb-1:0] wbe_a, wbe_b;
   word_t           rd_a, rd_b;
   logic            collision_d, collision_q;
   word_t           qa1_q, qa1_d, qb1_q, qb1_d, qa2_q, qa2_d, qb2_q, qb2_d;
   logic            va1_q, va1_d, vb1_q, vb1_d, va2_q, va2_d, vb2_q, vb2_d;
   logic            unused_addr;

   // Preloading from g_init_file is applied by simulation tooling; nothing to build.
   if ((g_clear_on_reset == 0) && (g_init_file != "")) begin : g_preload
   end

   urv_tcm_clear_fsm #(
      .g_words          (c_words),
      .g_clear_on_reset (g_clear_on_reset)
   ) u_clear_fsm (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .ready_o    (ready_o),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // Addresses wrap modulo g_size; byte-offset and upper bits are ignored.
   assign idx_a       = aa_i[c_top-1:c_ob];
   assign idx_b       = ab_i[c_top-1:c_ob];
   assign unused_addr = ^{aa_i, ab_i};

   // Access qualification and read data: own-port written bytes bypass, others old.
   always_comb begin
      acc_a = ready_o & ena_i;
      acc_b = ready_o & enb_i;
      wbe_a = (acc_a & wea_i) ? bwea_i : '0;
      wbe_b = (acc_b & web_i) ? bweb_i : '0;
      rd_a  = mem_q[idx_a];
      rd_b  = mem_q[idx_b];
      for (int unsigned k = 0; k < c_nb; k++) begin
         if (wbe_a[k]) rd_a[8*k +: 8] = da_i[8*k +: 8];
         if (wbe_b[k]) rd_b[8*k +: 8] = db_i[8*k +: 8];
      end
      collision_d = (|wbe_a) & (|wbe_b) & (idx_a == idx_b);
   end

   // Storage array: clear sweep, else byte writes with port A applied last so it wins.
   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else begin
         for (int unsigned k = 0; k < c_nb; k++) begin
            if (wbe_b[k]) mem_q[idx_b][8*k +: 8] <= db_i[8*k +: 8];
            if (wbe_a[k]) mem_q[idx_a][8*k +: 8] <= da_i[8*k +: 8];
         end
      end
   end

   // Output pipeline next-state: data holds between accesses, valids are per access.
   always_comb begin
      qa1_d = acc_a ? rd_a : qa1_q;
      qb1_d = acc_b ? rd_b : qb1_q;
      va1_d = acc_a;
      vb1_d = acc_b;
      qa2_d = qa1_q;
      qb2_d = qb1_q;
      va2_d = va1_q;
      vb2_d = vb1_q;
   end

   // Output pipeline and collision registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         qa1_q       <= '0;
         qb1_q       <= '0;
         va1_q       <= 1'b0;
         vb1_q       <= 1'b0;
         qa2_q       <= '0;
         qb2_q       <= '0;
         va2_q       <= 1'b0;
         vb2_q       <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         qa1_q       <= qa1_d;
         qb1_q       <= qb1_d;
         va1_q       <= va1_d;
         vb1_q       <= vb1_d;
         qa2_q       <= qa2_d;
         qb2_q       <= qb2_d;
         va2_q       <= va2_d;
         vb2_q       <= vb2_d;
         collision_q <= collision_d;
      end
   end

   assign qa_o        = (g_out_reg != 0) ? qa2_q : qa1_q;
   assign qb_o        = (g_out_reg != 0) ? qb2_q : qb1_q;
   assign qa_valid_o  = (g_out_reg != 0) ? va2_q : va1_q;
   assign qb_valid_o  = (g_out_reg != 0) ? vb2_q : vb1_q;
   assign collision_o = collision_q;

`ifdef URV_TCM_PARITY_EN
   logic [c_nb-1:0] par_q [c_words];
   logic [c_nb-1:0] rpar_a, rpar_b;
   logic            pa1_q, pa1_d, pb1_q, pb1_d, pa2_q, pa2_d, pb2_q, pb2_d;

   // Parity check on the returned word; bypassed bytes carry freshly computed parity.
   always_comb begin
      rpar_a = par_q[idx_a];
      rpar_b = par_q[idx_b];
      pa1_d  = 1'b0;
      pb1_d  = 1'b0;
      for (int unsigned k = 0; k < c_nb; k++) begin
         if (wbe_a[k]) rpar_a[k] = ^da_i[8*k +: 8];
         if (wbe_b[k]) rpar_b[k] = ^db_i[8*k +: 8];
         pa1_d = pa1_d | (rpar_a[k] ^ (^rd_a[8*k +: 8]));
         pb1_d = pb1_d | (rpar_b[k] ^ (^rd_b[8*k +: 8]));
      end
      pa1_d = pa1_d & acc_a;
      pb1_d = pb1_d & acc_b;
      pa2_d = pa1_q;
      pb2_d = pb1_q;
   end

   // Parity storage, written alongside the data bytes.
   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         par_q[clr_addr] <= '0;
      end else begin
         for (int unsigned k = 0; k < c_nb; k++) begin
            if (wbe_b[k]) par_q[idx_b][k] <= ^db_i[8*k +: 8];
            if (wbe_a[k]) par_q[idx_a][k] <= ^da_i[8*k +: 8];
         end
      end
   end

   // Parity error strobes, aligned with the valid pipeline.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pa1_q <= 1'b0;
         pb1_q <= 1'b0;
         pa2_q <= 1'b0;
         pb2_q <= 1'b0;
      end else begin
         pa1_q <= pa1_d;
         pb1_q <= pb1_d;
         pa2_q <= pa2_d;
         pb2_q <= pb2_d;
      end
   end

   assign perr_a_o = (g_out_reg != 0) ? pa2_q : pa1_q;
   assign perr_b_o = (g_out_reg != 0) ? pb2_q : pb1_q;
`endif

endmodule

// File: tb/tb_urv_tcm.sv
// tb_urv_tcm: self-checking bench for urv_tcm (1 KiB, 32-bit, clear enabled).
// Two instances share the stimulus: dut (latency 1) and dut_r (output register).
module tb_urv_tcm;

   localparam int unsigned SIZE = 1024;
   localparam int unsigned NW   = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena, wea, enb, web;
   logic [31:0] aa, ab, da, db;
   logic [3:0]  bwea, bweb;

   logic        ready0, qav0, qbv0, col0;
   logic [31:0] qa0, qb0;
   logic        ready1, qav1, qbv1, col1;
   logic [31:0] qa1, qb1;
`ifdef URV_TCM_PARITY_EN
   logic        perra0, perrb0, perra1, perrb1;
`endif

   always #5 clk = ~clk;

   urv_tcm #(
      .g_data_width(32), .g_size(SIZE), .g_out_reg(0), .g_clear_on_reset(1), .g_init_file("")
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .ready_o(ready0),
      .ena_i(ena), .wea_i(wea), .aa_i(aa), .bwea_i(bwea), .da_i(da), .qa_o(qa0), .qa_valid_o(qav0),
      .enb_i(enb), .web_i(web), .ab_i(ab), .bweb_i(bweb), .db_i(db), .qb_o(qb0), .qb_valid_o(qbv0),
      .collision_o(col0)
`ifdef URV_TCM_PARITY_EN
      , .perr_a_o(perra0), .perr_b_o(perrb0)
`endif
   );

   urv_tcm #(
      .g_data_width(32), .g_size(SIZE), .g_out_reg(1), .g_clear_on_reset(1), .g_init_file("")
   ) dut_r (
      .clk_i(clk), .rst_n_i(rst_n), .ready_o(ready1),
      .ena_i(ena), .wea_i(wea), .aa_i(aa), .bwea_i(bwea), .da_i(da), .qa_o(qa1), .qa_valid_o(qav1),
      .enb_i(enb), .web_i(web), .ab_i(ab), .bweb_i(bweb), .db_i(db), .qb_o(qb1), .qb_valid_o(qbv1),
      .collision_o(col1)
`ifdef URV_TCM_PARITY_EN
      , .perr_a_o(perra1), .perr_b_o(perrb1)
`endif
   );

   // Reference model state
   logic [31:0] mdl [NW];
   int unsigned clear_left;
   logic [31:0] e_qa1, e_qb1, e_qa2, e_qb2;
   bit          e_va1, e_vb1, e_va2, e_vb2, e_col, e_ready;
   int          bad_idx = -1;
   bit          e_pa1, e_pb1, e_pa2, e_pb2;
   int          checks = 0;
   int          errors = 0;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   task automatic model_reset();
      clear_left = NW;
      e_qa1 = '0; e_qb1 = '0; e_qa2 = '0; e_qb2 = '0;
      e_va1 = 0; e_vb1 = 0; e_va2 = 0; e_vb2 = 0;
      e_col = 0; e_ready = 0;
      e_pa1 = 0; e_pb1 = 0; e_pa2 = 0; e_pb2 = 0;
   endtask

   // One clock cycle of stimulus, model update and comparison of both instances.
   task automatic cyc(input bit ea, input bit wa, input logic [31:0] xa, input logic [3:0] ba,
                      input logic [31:0] wda, input bit eb, input bit wb, input logic [31:0] xb,
                      input logic [3:0] bb, input logic [31:0] wdb);
      int unsigned ia, ib;
      bit          rdy, acc_a, acc_b, col, pa, pb;
      logic [31:0] ra, rb;
      ena = ea; wea = wa; aa = xa; bwea = ba; da = wda;
      enb = eb; web = wb; ab = xb; bweb = bb; db = wdb;
      rdy   = (clear_left == 0);
      ia    = (xa % SIZE) / 4;
      ib    = (xb % SIZE) / 4;
      acc_a = ea && rdy;
      acc_b = eb && rdy;
      ra    = mdl[ia];
      rb    = mdl[ib];
      for (int k = 0; k < 4; k++) begin
         if (acc_a && wa && ba[k]) ra[k*8 +: 8] = wda[k*8 +: 8];
         if (acc_b && wb && bb[k]) rb[k*8 +: 8] = wdb[k*8 +: 8];
      end
      col = acc_a && wa && (ba != 0) && acc_b && wb && (bb != 0) && (ia == ib);
      pa  = acc_a && (int'(ia) == bad_idx) && !(wa && ba[0]);
      pb  = acc_b && (int'(ib) == bad_idx) && !(wb && bb[0]);
      for (int k = 0; k < 4; k++)
         if (acc_b && wb && bb[k]) mdl[ib][k*8 +: 8] = wdb[k*8 +: 8];
      for (int k = 0; k < 4; k++)
         if (acc_a && wa && ba[k]) mdl[ia][k*8 +: 8] = wda[k*8 +: 8];
      if ((acc_a && wa && ba[0] && int'(ia) == bad_idx) ||
          (acc_b && wb && bb[0] && int'(ib) == bad_idx)) bad_idx = -1;
      if (!rdy) begin
         if (int'(NW - clear_left) == bad_idx) bad_idx = -1;
         mdl[NW - clear_left] = '0;
         clear_left--;
      end
      @(posedge clk); #1;
      e_qa2 = e_qa1; e_qb2 = e_qb1; e_va2 = e_va1; e_vb2 = e_vb1;
      e_pa2 = e_pa1; e_pb2 = e_pb1;
      if (acc_a) e_qa1 = ra;
      if (acc_b) e_qb1 = rb;
      e_va1 = acc_a; e_vb1 = acc_b; e_col = col; e_ready = (clear_left == 0);
      e_pa1 = pa; e_pb1 = pb;
      checks++;
      if ({ready0, col0, qav0, qbv0, qa0, qb0} !== {e_ready, e_col, e_va1, e_vb1, e_qa1, e_qb1}) begin
         errors++;
         $display("FAIL lat1 t=%0t got rdy,col,va,vb,qa,qb=%h required %h", $time,
                  {ready0, col0, qav0, qbv0, qa0, qb0}, {e_ready, e_col, e_va1, e_vb1, e_qa1, e_qb1});
      end
      checks++;
      if ({ready1, col1, qav1, qbv1, qa1, qb1} !== {e_ready, e_col, e_va2, e_vb2, e_qa2, e_qb2}) begin
         errors++;
         $display("FAIL lat2 t=%0t got rdy,col,va,vb,qa,qb=%h required %h", $time,
                  {ready1, col1, qav1, qbv1, qa1, qb1}, {e_ready, e_col, e_va2, e_vb2, e_qa2, e_qb2});
      end
`ifdef URV_TCM_PARITY_EN
      checks++;
      if ({perra0, perrb0, perra1, perrb1} !== {e_pa1, e_pb1, e_pa2, e_pb2}) begin
         errors++;
         $display("FAIL perr t=%0t got %b required %b", $time,
                  {perra0, perrb0, perra1, perrb1}, {e_pa1, e_pb1, e_pa2, e_pb2});
      end
`endif
   endtask

   task automatic idle();
      cyc(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready0, col0, qav0, qbv0, qa0, qb0, ready1, col1, qav1, qbv1, qa1, qb1} !== '0) begin
         errors++;
         $display("FAIL reset_state got %h required 0",
                  {ready0, col0, qav0, qbv0, qa0, qb0, ready1, col1, qav1, qbv1, qa1, qb1});
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ready0, ready1} !== 2'b00) begin
         errors++;
         $display("FAIL reset_hold ready got %b required 00", {ready0, ready1});
      end
      rst_n = 1'b1;
   endtask

   // Counts ready-low cycles from reset release, with optional write/read attempts.
   task automatic run_clear(input bit poke, input string name);
      int zeros = 0;
      for (int i = 0; i < 400; i++) begin
         if (ready0 === 1'b1) break;
         zeros++;
         if (poke) cyc(1, 1, 32'h0, 4'hF, 32'hFFFF_FFFF, 1, 1, 32'h4, 4'hF, 32'hFFFF_FFFF);
         else      idle();
      end
      checks++;
      if (zeros != int'(NW)) begin
         errors++;
         $display("FAIL %s ready-low cycles got %0d required %0d", name, zeros, NW);
      end
   endtask

   task automatic test_clear();
      run_clear(0, "clear_len");
      cyc(1, 0, 32'h3FC, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
      checks++;
      if ({qav0, qa0} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL clear_read got valid,q=%h required 100000000", {qav0, qa0});
      end
   endtask

   task automatic test_byte_write();
      cyc(0, 0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h10, 4'b0101, 32'hDEAD_BEEF);
      cyc(1, 0, 32'h10, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
      checks++;
      if (qa0 !== 32'h00AD_00EF) begin
         errors++;
         $display("FAIL byte_write got %h required 00ad00ef", qa0);
      end
      cyc(1, 0, 32'h410, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
      checks++;
      if (qa0 !== 32'h00AD_00EF) begin
         errors++;
         $display("FAIL alias_read got %h required 00ad00ef", qa0);
      end
   endtask

   task automatic test_collision();
      cyc(1, 1, 32'h20, 4'b0011, 32'h1111_1111, 1, 1, 32'h20, 4'b1111, 32'h2222_2222);
      checks++;
      if (col0 !== 1'b1) begin
         errors++;
         $display("FAIL collision_pulse got %b required 1", col0);
      end
      cyc(1, 0, 32'h20, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
      checks++;
      if ({col0, qa0} !== {1'b0, 32'h2222_1111}) begin
         errors++;
         $display("FAIL collision_word got col,q=%h required 022221111", {col0, qa0});
      end
   endtask

   task automatic test_rdw();
      cyc(1, 1, 32'h30, 4'hF, 32'h0102_0304, 0, 0, 32'h0, 4'h0, 32'h0);
      cyc(1, 1, 32'h30, 4'b1100, 32'hAABB_CCDD, 1, 0, 32'h30, 4'h0, 32'h0);
      checks++;
      if ({qa0, qb0} !== {32'hAABB_0304, 32'h0102_0304}) begin
         errors++;
         $display("FAIL rdw got qa,qb=%h required aabb030401020304", {qa0, qb0});
      end
   endtask

   task automatic test_back_to_back();
      int hi = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 32'h10 + 32'(i * 16), 4'h0, 32'h0, 1, 0, 32'h20, 4'h0, 32'h0);
         if (qav0 === 1'b1 && qbv0 === 1'b1) hi++;
      end
      checks++;
      if (hi != 4) begin
         errors++;
         $display("FAIL back_to_back valid cycles got %0d required 4", hi);
      end
   endtask

   task automatic test_out_reg();
      logic [31:0] dat [3];
      int hi = 0;
      int first = -1;
      cyc(1, 1, 32'h100, 4'hF, 32'hA0A0_A001, 1, 1, 32'h104, 4'hF, 32'hB0B0_B002);
      cyc(1, 1, 32'h108, 4'hF, 32'hC0C0_C003, 0, 0, 32'h0, 4'h0, 32'h0);
      idle();
      for (int i = 0; i < 6; i++) begin
         if (i < 3) cyc(1, 0, 32'h100 + 32'(4 * i), 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
         else       idle();
         if (qav1 === 1'b1) begin
            if (first < 0) first = i;
            if (hi < 3) dat[hi] = qa1;
            hi++;
         end
      end
      checks++;
      if (hi != 3 || first != 1) begin
         errors++;
         $display("FAIL out_reg_valid got count=%0d first=%0d required count=3 first=1", hi, first);
      end
      checks++;
      if (hi == 3 && {dat[0], dat[1], dat[2]} !== {32'hA0A0_A001, 32'hB0B0_B002, 32'hC0C0_C003}) begin
         errors++;
         $display("FAIL out_reg_data got %h %h %h required a0a0a001 b0b0b002 c0c0c003",
                  dat[0], dat[1], dat[2]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [31:0] xa, xb;
         xa = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
         xb = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
         cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), xa, 4'($urandom), $urandom,
             bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), xb, 4'($urandom), $urandom);
      end
   endtask

`ifdef URV_TCM_PARITY_EN
   task automatic test_parity();
      cyc(1, 1, 32'h40, 4'hF, 32'h1234_5678, 1, 1, 32'h44, 4'hF, 32'h8765_4321);
      dut.par_q[16][0]   = ~dut.par_q[16][0];
      dut_r.par_q[16][0] = ~dut_r.par_q[16][0];
      bad_idx = 16;
      cyc(1, 0, 32'h40, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
      checks++;
      if ({perra0, qav0} !== 2'b11) begin
         errors++;
         $display("FAIL parity_bad got perr,valid=%b required 11", {perra0, qav0});
      end
      cyc(1, 0, 32'h44, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
      checks++;
      if ({perra0, qav0} !== 2'b01) begin
         errors++;
         $display("FAIL parity_clean got perr,valid=%b required 01", {perra0, qav0});
      end
      idle();
   endtask
`endif

   task automatic test_reset_mid_clear();
      cyc(1, 1, 32'h50, 4'hF, 32'h5A5A_5A5A, 0, 0, 32'h0, 4'h0, 32'h0);
      cyc(1, 0, 32'h50, 4'h0, 32'h0, 1, 0, 32'h50, 4'h0, 32'h0);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready0, qav0, qbv0, qa0, qb0, ready1, qa1} !== '0) begin
         errors++;
         $display("FAIL reset_immediate got %h required 0", {ready0, qav0, qbv0, qa0, qb0, ready1, qa1});
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++)
         cyc(1, 1, 32'h0, 4'hF, 32'hFFFF_FFFF, 1, 1, 32'h4, 4'hF, 32'hFFFF_FFFF);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready0, col0, qav0, qbv0, qa0, qb0} !== '0) begin
         errors++;
         $display("FAIL reset_mid_clear got %h required 0", {ready0, col0, qav0, qbv0, qa0, qb0});
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_clear(1, "reclear_len");
      cyc(1, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h4, 4'h0, 32'h0);
      checks++;
      if ({qav0, qa0, qbv0, qb0} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL dropped_writes got %h required 1000000001_00000000", {qav0, qa0, qbv0, qb0});
      end
   endtask

   initial begin
      rst_n = 1'b1;
      ena = 0; wea = 0; aa = '0; bwea = '0; da = '0;
      enb = 0; web = 0; ab = '0; bweb = '0; db = '0;
      for (int i = 0; i < int'(NW); i++) mdl[i] = $urandom;
      model_reset();
      #2;
      test_reset();
      test_clear();
      test_byte_write();
      test_collision();
      test_rdw();
      test_back_to_back();
      test_out_reg();
      test_random();
`ifdef URV_TCM_PARITY_EN
      test_parity();
`endif
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
